// File: rtl/doodle_pkg.sv
// Shared defaults, state encoding and helpers for the doodle game-loop scheduler.
package doodle_pkg;

    localparam int unsigned H_RES_DEF       = 640;
    localparam int unsigned V_RES_DEF       = 480;
    localparam int unsigned SCROLL_LINE_DEF = 160;
    localparam int unsigned N_PLAT_DEF      = 8;

    localparam int unsigned NUM_STATES = 6;

    typedef enum logic [NUM_STATES-1:0] {
        StIdle   = 6'b000001,
        StWait   = 6'b000010,
        StPhys   = 6'b000100,
        StColl   = 6'b001000,
        StScroll = 6'b010000,
        StDone   = 6'b100000
    } state_e;

    // Bits needed to index 'value' items; never less than one.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < value) width = i + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/doodle_step_scheduler_if.sv
// Handshake bundle between the scheduler and the VGA timing, physics, collision and scroll blocks.
interface doodle_step_scheduler_if
    import doodle_pkg::*;
#(
    parameter int unsigned N_PLAT = N_PLAT_DEF
);

    localparam int unsigned PLAT_W = clog2(N_PLAT);

    logic              start;
    logic              ack;
    logic [9:0]        hcount;
    logic [9:0]        vcount;
    logic [9:0]        doodle_y;
    logic              doodle_falling;
    logic              phys_go;
    logic              phys_done;
    logic [PLAT_W-1:0] plat_sel;
    logic              coll_go;
    logic              coll_valid;
    logic              coll_hit;
    logic              bounce;
    logic              scroll_go;
    logic [9:0]        scroll_amt;
    logic              scroll_done;
    logic              q_i;
    logic              q_play;
    logic              q_done;
    logic [15:0]       step_cnt;
    logic              overrun;
    logic              timeout_err;

    modport master (
        input  start, ack, hcount, vcount, doodle_y, doodle_falling,
        input  phys_done, coll_valid, coll_hit, scroll_done,
        output phys_go, plat_sel, coll_go, bounce, scroll_go, scroll_amt,
        output q_i, q_play, q_done, step_cnt, overrun, timeout_err
    );

    modport slave (
        output start, ack, hcount, vcount, doodle_y, doodle_falling,
        output phys_done, coll_valid, coll_hit, scroll_done,
        input  phys_go, plat_sel, coll_go, bounce, scroll_go, scroll_amt,
        input  q_i, q_play, q_done, step_cnt, overrun, timeout_err
    );

endinterface

// File: rtl/frame_tick_gen.sv
// Frame strobe detector plus a frames-per-step divider; step_due pulses on the wrapping strobe.
module frame_tick_gen
    import doodle_pkg::*;
#(
    parameter int unsigned V_RES    = V_RES_DEF,
    parameter int unsigned TICK_DIV = 2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_clr,
    input  logic [9:0] i_hcount,
    input  logic [9:0] i_vcount,
    output logic       o_step_due
);

    localparam int unsigned DIV_W    = clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [9:0]       V_STROBE = 10'(V_RES);

    logic             r_strobe;
    logic [DIV_W-1:0] r_div;
    logic             w_wrap;

    assign w_wrap     = (r_div == DIV_LAST);
    assign o_step_due = r_strobe && w_wrap;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_strobe <= 1'b0;
            r_div    <= '0;
        end else begin
            r_strobe <= (i_hcount == 10'd0) && (i_vcount == V_STROBE);
            if (i_clr) begin
                r_div <= '0;
            end else if (r_strobe) begin
                r_div <= w_wrap ? '0 : r_div + 1'b1;
            end
        end
    end

endmodule

// File: rtl/doodle_step_scheduler.sv
// Game-loop controller: every TICK_DIV frames runs physics, a platform collision sweep and a scroll.
module doodle_step_scheduler
    import doodle_pkg::*;
#(
    parameter int unsigned V_RES       = V_RES_DEF,
    parameter int unsigned TICK_DIV    = 2,
    parameter int unsigned N_PLAT      = N_PLAT_DEF,
    parameter int unsigned SCROLL_LINE = SCROLL_LINE_DEF,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    doodle_step_scheduler_if.master bus
);

    localparam int unsigned PLAT_W = clog2(N_PLAT);
    localparam int unsigned WAIT_W = clog2(TIMEOUT + 1);

    localparam logic [PLAT_W-1:0] PLAT_LAST  = PLAT_W'(N_PLAT - 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT);
    localparam logic [9:0]        Y_FLOOR    = 10'(V_RES - 1);
    localparam logic [9:0]        Y_SCROLL   = 10'(SCROLL_LINE);

    state_e            r_state, w_state_d;
    logic              r_go, w_go_d;
    logic [PLAT_W-1:0] r_plat_sel, w_plat_sel_d;
    logic [15:0]       r_step_cnt, w_step_cnt_d;
    logic              r_overrun, w_overrun_d;
    logic              r_timeout_err, w_timeout_err_d;
    logic [WAIT_W-1:0] r_wait_cnt, w_wait_cnt_d;
    logic              r_bounce, w_bounce_d;
    logic [9:0]        r_scroll_amt, w_scroll_amt_d;

    logic w_step_due;
    logic w_clr_div;
    logic w_expired;
    logic w_busy;
    logic w_check;

    frame_tick_gen #(
        .V_RES    (V_RES),
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_clr      (w_clr_div),
        .i_hcount   (bus.hcount),
        .i_vcount   (bus.vcount),
        .o_step_due (w_step_due)
    );

    assign w_expired = (r_wait_cnt == WAIT_LIMIT);
    assign w_busy    = (r_state == StPhys) || (r_state == StColl) || (r_state == StScroll);

    always_comb begin
        w_state_d       = r_state;
        w_go_d          = 1'b0;
        w_plat_sel_d    = r_plat_sel;
        w_step_cnt_d    = r_step_cnt;
        w_overrun_d     = r_overrun;
        w_timeout_err_d = r_timeout_err;
        w_wait_cnt_d    = r_wait_cnt + 1'b1;
        w_bounce_d      = 1'b0;
        w_scroll_amt_d  = r_scroll_amt;
        w_clr_div       = 1'b0;
        w_check         = 1'b0;

        // A step that comes due mid-step is dropped, only flagged.
        if (w_busy && w_step_due) w_overrun_d = 1'b1;

        unique case (r_state)
            StIdle: begin
                if (bus.start) begin
                    w_state_d       = StWait;
                    w_step_cnt_d    = '0;
                    w_overrun_d     = 1'b0;
                    w_timeout_err_d = 1'b0;
                    w_clr_div       = 1'b1;
                end
            end
            StWait: begin
                if (w_step_due) begin
                    w_state_d    = StPhys;
                    w_go_d       = 1'b1;
                    w_wait_cnt_d = '0;
                    w_step_cnt_d = r_step_cnt + 16'd1;
                end
            end
            StPhys: begin
                if (bus.phys_done) begin
                    if (bus.doodle_falling && (bus.doodle_y >= Y_FLOOR)) begin
                        w_state_d = StDone;
                    end else if (bus.doodle_falling) begin
                        w_state_d    = StColl;
                        w_go_d       = 1'b1;
                        w_wait_cnt_d = '0;
                        w_plat_sel_d = '0;
                    end else begin
                        w_check = 1'b1;
                    end
                end else if (w_expired) begin
                    w_timeout_err_d = 1'b1;
                    w_state_d       = StWait;
                end
            end
            StColl: begin
                if (bus.coll_valid) begin
                    if (bus.coll_hit) begin
                        w_bounce_d = 1'b1;
                        w_check    = 1'b1;
                    end else if (r_plat_sel == PLAT_LAST) begin
                        w_check = 1'b1;
                    end else begin
                        w_plat_sel_d = r_plat_sel + 1'b1;
                        w_go_d       = 1'b1;
                        w_wait_cnt_d = '0;
                    end
                end else if (w_expired) begin
                    w_timeout_err_d = 1'b1;
                    w_state_d       = StWait;
                end
            end
            StScroll: begin
                if (bus.scroll_done) begin
                    w_state_d = StWait;
                end else if (w_expired) begin
                    w_timeout_err_d = 1'b1;
                    w_state_d       = StWait;
                end
            end
            StDone: begin
                if (bus.ack) w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase

        // Zero-cycle scroll decision shared by the physics and collision exits.
        if (w_check) begin
            if (bus.doodle_y < Y_SCROLL) begin
                w_state_d      = StScroll;
                w_go_d         = 1'b1;
                w_wait_cnt_d   = '0;
                w_scroll_amt_d = Y_SCROLL - bus.doodle_y;
            end else begin
                w_state_d = StWait;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= StIdle;
            r_go          <= 1'b0;
            r_plat_sel    <= '0;
            r_step_cnt    <= '0;
            r_overrun     <= 1'b0;
            r_timeout_err <= 1'b0;
            r_wait_cnt    <= '0;
            r_bounce      <= 1'b0;
            r_scroll_amt  <= '0;
        end else begin
            r_state       <= w_state_d;
            r_go          <= w_go_d;
            r_plat_sel    <= w_plat_sel_d;
            r_step_cnt    <= w_step_cnt_d;
            r_overrun     <= w_overrun_d;
            r_timeout_err <= w_timeout_err_d;
            r_wait_cnt    <= w_wait_cnt_d;
            r_bounce      <= w_bounce_d;
            r_scroll_amt  <= w_scroll_amt_d;
        end
    end

    assign bus.phys_go     = r_go && (r_state == StPhys);
    assign bus.coll_go     = r_go && (r_state == StColl);
    assign bus.scroll_go   = r_go && (r_state == StScroll);
    assign bus.plat_sel    = r_plat_sel;
    assign bus.bounce      = r_bounce;
    assign bus.scroll_amt  = (r_state == StScroll) ? r_scroll_amt : 10'd0;
    assign bus.q_i         = (r_state == StIdle);
    assign bus.q_play      = w_busy || (r_state == StWait);
    assign bus.q_done      = (r_state == StDone);
    assign bus.step_cnt    = r_step_cnt;
    assign bus.overrun     = r_overrun;
    assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_doodle_step_scheduler.sv
// Randomized and directed bench for doodle_step_scheduler against a per-step outcome model.
module tb_doodle_step_scheduler;

    localparam int unsigned V_RES       = 480;
    localparam int unsigned TICK_DIV    = 2;
    localparam int unsigned N_PLAT      = 8;
    localparam int unsigned SCROLL_LINE = 160;
    localparam int unsigned TIMEOUT     = 255;

    logic clk;
    logic reset;

    doodle_step_scheduler_if #(.N_PLAT(N_PLAT)) bus ();

    doodle_step_scheduler #(
        .V_RES       (V_RES),
        .TICK_DIV    (TICK_DIV),
        .N_PLAT      (N_PLAT),
        .SCROLL_LINE (SCROLL_LINE),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int n_phys, n_coll, n_bounce, n_scroll;
    int ph_cnt = 0, cv_cnt = 0, sd_cnt = 0;
    int phys_lat = 3, coll_lat = 2, scroll_lat = 2;
    int hit_idx = -1;
    bit withhold = 1'b0;
    int got_amt, exp_amt;
    int cyc = 0, go_cyc = 0, te_cyc = -1;
    int step_exp = 0;
    int exp_over = 0, exp_tmo = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Environment: answers go pulses after programmable latencies and tallies pulses.
    always @(negedge clk) begin
        cyc++;
        bus.phys_done   = 1'b0;
        bus.coll_valid  = 1'b0;
        bus.coll_hit    = 1'b0;
        bus.scroll_done = 1'b0;
        if (reset) begin
            ph_cnt = 0;
            cv_cnt = 0;
            sd_cnt = 0;
        end else begin
            if (bus.phys_go) begin
                n_phys++;
                ph_cnt = phys_lat;
            end else if (ph_cnt > 0) begin
                ph_cnt--;
                if (ph_cnt == 0) bus.phys_done = 1'b1;
            end
            if (bus.coll_go) begin
                check_val("plat_sel_order", 32'(bus.plat_sel), n_coll);
                n_coll++;
                cv_cnt = coll_lat;
            end else if (cv_cnt > 0) begin
                cv_cnt--;
                if (cv_cnt == 0) begin
                    bus.coll_valid = 1'b1;
                    bus.coll_hit   = (hit_idx == int'(bus.plat_sel));
                end
            end
            if (bus.bounce) n_bounce++;
            if (bus.scroll_go) begin
                n_scroll++;
                got_amt = int'(bus.scroll_amt);
                go_cyc  = cyc;
                if (!withhold) sd_cnt = scroll_lat;
            end else if (sd_cnt > 0) begin
                sd_cnt--;
                if (sd_cnt == 0) begin
                    bus.scroll_done = 1'b1;
                    check_val("scroll_amt_held", 32'(bus.scroll_amt), exp_amt);
                end
            end
            if (bus.timeout_err && te_cyc < 0) te_cyc = cyc;
        end
    end

    task automatic frame();
        @(negedge clk);
        bus.hcount = 10'd0;
        bus.vcount = 10'(V_RES);
        @(negedge clk);
        bus.hcount = 10'd5;
        bus.vcount = 10'd0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        bus.ack = 1'b1;
        @(negedge clk);
        bus.ack = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check_val("rst_pulses_flags", 32'({bus.phys_go, bus.coll_go, bus.bounce, bus.scroll_go,
                  bus.q_play, bus.q_done, bus.overrun, bus.timeout_err}), 0);
        check_val("rst_q_i", 32'(bus.q_i), 1);
        check_val("rst_sel_amt", 32'({bus.plat_sel, bus.scroll_amt}), 0);
        check_val("rst_step_cnt", 32'(bus.step_cnt), 0);
    endtask

    // One game step: model predicts pulse counts and final flags from the step's inputs.
    task automatic run_step(input bit f, input int y, input int hit);
        int e_done, e_coll, e_bounce, e_scroll;
        bus.doodle_falling = f;
        bus.doodle_y       = 10'(y);
        hit_idx            = hit;
        e_done   = (f && y >= int'(V_RES) - 1) ? 1 : 0;
        e_coll   = (!f || e_done == 1) ? 0 : ((hit < 0) ? int'(N_PLAT) : hit + 1);
        e_bounce = (f && e_done == 0 && hit >= 0) ? 1 : 0;
        e_scroll = (e_done == 0 && y < int'(SCROLL_LINE)) ? 1 : 0;
        exp_amt  = int'(SCROLL_LINE) - y;
        n_phys = 0; n_coll = 0; n_bounce = 0; n_scroll = 0;
        repeat (TICK_DIV - 1) frame();
        repeat (4) @(negedge clk);
        check_val("div_gate", n_phys, 0);
        frame();
        @(negedge clk);
        check_val("phys_go_latency", 32'(bus.phys_go), 1);
        step_exp = (step_exp + 1) % 65536;
        repeat (60) @(negedge clk);
        check_val("n_phys_go", n_phys, 1);
        check_val("n_coll_go", n_coll, e_coll);
        check_val("n_bounce", n_bounce, e_bounce);
        check_val("n_scroll_go", n_scroll, e_scroll);
        if (e_scroll == 1) check_val("scroll_amt", got_amt, exp_amt);
        check_val("step_cnt", 32'(bus.step_cnt), step_exp);
        check_val("q_done", 32'(bus.q_done), e_done);
        check_val("q_play", 32'(bus.q_play), 1 - e_done);
        check_val("overrun", 32'(bus.overrun), exp_over);
        check_val("timeout_err", 32'(bus.timeout_err), exp_tmo);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int snap;
        int d;
        reset              = 1'b1;
        bus.start          = 1'b0;
        bus.ack            = 1'b0;
        bus.hcount         = 10'd5;
        bus.vcount         = 10'd0;
        bus.doodle_y       = 10'd300;
        bus.doodle_falling = 1'b0;
        bus.phys_done      = 1'b0;
        bus.coll_valid     = 1'b0;
        bus.coll_hit       = 1'b0;
        bus.scroll_done    = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        reset = 1'b0;

        // Basic step, then collision sweep with a hit on platform 5, then scroll.
        pulse_start();
        check_val("start_q_play", 32'(bus.q_play), 1);
        run_step(1'b0, 300, -1);
        run_step(1'b1, 300, 5);
        run_step(1'b0, 100, -1);

        // Falling off the bottom ends the game; Start is ignored until Ack.
        run_step(1'b1, 479, -1);
        pulse_start();
        check_val("done_ignores_start", 32'(bus.q_done), 1);
        check_val("done_step_cnt", 32'(bus.step_cnt), step_exp);
        pulse_ack();
        check_val("ack_q_i", 32'(bus.q_i), 1);
        pulse_start();
        step_exp = 0;
        check_val("restart_step_cnt", 32'(bus.step_cnt), 0);

        // Withheld scroll_done: overrun on the next step_due, then handshake timeout.
        withhold = 1'b1;
        te_cyc   = -1;
        run_step(1'b0, 100, -1);
        repeat (TICK_DIV) frame();
        repeat (2) @(negedge clk);
        check_val("overrun_set", 32'(bus.overrun), 1);
        check_val("overrun_dropped", 32'(bus.step_cnt), step_exp);
        repeat (260) @(negedge clk);
        check_val("timeout_set", 32'(bus.timeout_err), 1);
        d = te_cyc - go_cyc;
        check_val("timeout_delay", (te_cyc >= 0 && d >= int'(TIMEOUT) && d <= int'(TIMEOUT) + 2), 1);
        check_val("timeout_no_scroll", n_scroll, 1);
        check_val("timeout_q_play", 32'(bus.q_play), 1);
        withhold = 1'b0;
        exp_over = 1;
        exp_tmo  = 1;
        run_step(1'b0, 300, -1);

        // Reset in the middle of a sweep.
        coll_lat           = 3;
        hit_idx            = -1;
        bus.doodle_falling = 1'b1;
        bus.doodle_y       = 10'd300;
        n_coll             = 0;
        repeat (TICK_DIV) frame();
        for (int i = 0; i < 60 && n_coll < 3; i++) @(negedge clk);
        check_val("mid_coll_reached", (n_coll >= 3), 1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        reset = 1'b0;
        snap  = n_phys + n_coll + n_bounce + n_scroll;
        repeat (TICK_DIV) frame();
        repeat (30) @(negedge clk);
        check_val("no_go_after_reset", n_phys + n_coll + n_bounce + n_scroll, snap);
        check_val("idle_after_reset", 32'(bus.q_i), 1);

        // Randomized steps.
        pulse_start();
        step_exp = 0;
        exp_over = 0;
        exp_tmo  = 0;
        for (int s = 0; s < 16; s++) begin
            bit f;
            int y;
            int hit;
            f          = 1'($urandom_range(0, 1));
            y          = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 159))
                                                     : int'($urandom_range(160, 478));
            hit        = int'($urandom_range(0, 8)) - 1;
            phys_lat   = int'($urandom_range(1, 5));
            coll_lat   = int'($urandom_range(1, 3));
            scroll_lat = int'($urandom_range(1, 4));
            run_step(f, y, hit);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/doodle_step_scheduler.md
Name: doodle_step_scheduler

Overview:
- Game-loop controller for the doodle datapath. Once per N video frames it runs one game step: physics update, then a platform collision sweep, then a camera scroll.
- Sits between the VGA timing counters and the physics, collision and scroll blocks, and owns the game-level I / PLAY / DONE lifecycle.
- Sequences the shared collision checker one platform at a time.

Parameters:
- H_RES, 640, active horizontal pixels.
- V_RES, 480, active vertical lines; the frame strobe fires at vCount==V_RES.
- TICK_DIV, 2, frames per game step (>=1).
- N_PLAT, 8, platforms swept per step (power of 2, <=16).
- SCROLL_LINE, 160, doodle_y below this value triggers a scroll.
- TIMEOUT, 255, maximum cycles spent waiting on any *_done or coll_valid.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  begin game; honoured only in IDLE.
- Ack  in  1  leave DONE.
- hCount  in  10  VGA horizontal counter.
- vCount  in  10  VGA vertical counter.
- doodle_y  in  10  doodle top y, from physics.
- doodle_falling  in  1  doodle moving down.
- phys_go  out  1  one-cycle physics step request.
- phys_done  in  1  physics step complete.
- plat_sel  out  log2(N_PLAT)  platform index under test.
- coll_go  out  1  one-cycle collision check request.
- coll_valid  in  1  collision result valid.
- coll_hit  in  1  doodle overlaps plat_sel.
- bounce  out  1  one-cycle pulse: restart the jump.
- scroll_go  out  1  one-cycle scroll request.
- scroll_amt  out  10  lines to scroll.
- scroll_done  in  1  scroll complete.
- q_I, q_Play, q_Done  out  1 each  state flags.
- step_cnt  out  16  steps executed since Start.
- overrun  out  1  sticky: frame strobe missed.
- timeout_err  out  1  sticky: handshake timeout.

Behaviour:
- Synchronous reset. All outputs are 0 and q_I=1. The FSM goes to IDLE and the divider and counters clear. A reset mid-step abandons the step with no further go pulses.
- Frame strobe:
  - Registered, high for one cycle after a cycle where hCount==0 && vCount==V_RES.
  - A divider counts strobes 0..TICK_DIV-1; step_due is raised on the strobe that wraps it.
- States (one-hot): IDLE, WAIT, PHYS, COLL, SCROLL, DONE. q_Play is high in WAIT, PHYS, COLL and SCROLL.
- IDLE:
  - On Start: go to WAIT; clear step_cnt, the divider, overrun and timeout_err.
- WAIT:
  - On step_due: go to PHYS and increment step_cnt (wraps at 2^16).
- PHYS:
  - phys_go is high on the first cycle in the state only. Then wait for phys_done.
  - On phys_done:
    - If doodle_falling && doodle_y >= V_RES-1, go to DONE.
    - Otherwise, if doodle_falling, go to COLL with plat_sel=0.
    - Otherwise, go to the scroll check.
- COLL:
  - coll_go pulses once per platform; plat_sel is stable from coll_go until coll_valid.
  - On coll_valid && coll_hit: bounce pulses next cycle, the sweep ends, and the FSM goes to the scroll check. A hit on platform N_PLAT-1 behaves the same.
  - On coll_valid && !coll_hit: if plat_sel==N_PLAT-1, go to the scroll check; otherwise increment plat_sel and pulse coll_go again.
- Scroll check (0 cycles):
  - If doodle_y < SCROLL_LINE: scroll_amt = SCROLL_LINE - doodle_y (unsigned, always >0), go to SCROLL, and pulse scroll_go.
  - Otherwise go to WAIT.
- SCROLL:
  - scroll_amt is held until scroll_done, then go to WAIT.
- DONE:
  - Ack returns the FSM to IDLE. Start is ignored outside IDLE.
- Overrun:
  - A step_due arriving in PHYS, COLL or SCROLL sets overrun.
  - The missed step is dropped, not queued.
- Timeout:
  - A wait counter restarts on every go pulse.
  - When the awaited input is not seen within TIMEOUT cycles: set timeout_err and return to WAIT. No bounce or scroll is issued for that step.
- Simultaneous events:
  - A done/valid input arriving in the same cycle as the timeout expiry counts as success.
  - Reset dominates Start and Ack.
- Latency: phys_go is asserted 1 cycle after the step_due strobe.

Decomposition:
- doodle_pkg holds:
  - the state encoding localparams;
  - H_RES, V_RES, SCROLL_LINE and N_PLAT defaults;
  - a shared clog2 function.
- Sub-module frame_tick_gen contains the strobe detector and TICK_DIV divider and outputs step_due. The scheduler FSM stays in the top module.

Test Plan:
- Reset, Start, run 2 frames with TICK_DIV=2, phys_done 3 cycles after phys_go, not falling, doodle_y=300 -> exactly one phys_go, no coll_go or scroll_go, step_cnt=1, back in WAIT.
- Falling, doodle_y=300, coll_hit only at platform 5 -> coll_go for plat_sel 0..5 only, one bounce pulse, no scroll_go.
- Not falling, doodle_y=100 -> scroll_go once, scroll_amt=60 held until scroll_done.
- Falling, doodle_y=479 at phys_done -> q_Done=1, no coll_go. Ack -> q_I=1. Start while in DONE is ignored.
- Withhold scroll_done across the next step_due -> overrun=1. Withhold past 255 cycles -> timeout_err=1 and FSM in WAIT.
- Assert Reset mid-COLL -> next cycle all outputs 0, q_I=1, no further go pulses.
